instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//   Fetch sequencer for the single-cycle instruction memory (8-bit word address, 32-bit word).
//   Holds the program counter, drives the memory address and registers each fetched word into
//   an output stage with a valid/ready handshake toward the decoder.
//   Supports start, branch/jump redirect with flush, decoder back-pressure, halt-word detection
//   and an issued-instruction counter.
// PARAMETERS
//   ADDR_W    8             memory word-address width; the PC wraps modulo 2**ADDR_W
//   DATA_W    32            instruction width
//   RESET_PC  0             PC value after reset
//   HALT_WORD 32'hFC000000  encoding (opcode 6'b111111) that stops fetching; never issued
//   CNT_W     16            width of the issued-instruction counter
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       synchronous, active-high reset
//   start        in   1       IDLE -> RUN request (single-cycle pulse or level)
//   redirect     in   1       load redirect_pc into the PC and flush the output stage
//   redirect_pc  in   ADDR_W  redirect target
//   imem_addr    out  ADDR_W  memory address; combinational copy of the PC
//   imem_rd      in   DATA_W  memory read data, combinational from imem_addr
//   instr        out  DATA_W  registered instruction presented to the decoder
//   instr_pc     out  ADDR_W  address that instr was fetched from
//   instr_valid  out  1       instr/instr_pc hold a valid instruction
//   instr_ready  in   1       decoder accepts; a transfer occurs when instr_valid && instr_ready
//   halted       out  1       high while the FSM is in HALT
//   issue_cnt    out  CNT_W   instructions loaded into the output stage; saturates at all-ones
// BEHAVIOUR
//   Reset (sampled at a clk edge with rst=1): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0,
//     instr_valid=0, halted=0, issue_cnt=0. rst overrides every other input, including mid-stall.
//   Output register: imem_addr = pc at all times. No other output is combinational.
//   IDLE
//     - start=1 -> RUN on the next edge.
//     - redirect=1 -> pc<=redirect_pc and state stays IDLE. If start and redirect are both 1,
//       pc is loaded and the FSM enters RUN.
//   RUN: priority is redirect > halt detect > load > hold.
//     - redirect=1: pc<=redirect_pc, instr_valid<=0 (flushes any unaccepted word), no load.
//     - Load condition: (!instr_valid || instr_ready) and imem_rd != HALT_WORD.
//       On load: instr<=imem_rd, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (255 -> 0 wrap), and
//       issue_cnt increments (saturating).
//     - Halt: the same slot condition holds but imem_rd == HALT_WORD. Then state<=HALT,
//       halted<=1, pc is held at the halt address, instr_valid<=0, and the word is not issued.
//     - Otherwise (stall: valid && !ready): all registers hold.
//   HALT
//     - No loads. Only redirect=1 exits: pc<=redirect_pc, halted<=0, state<=RUN.
//     - start is ignored in HALT.
//   Latency: start sampled at edge N -> RUN at N; first load at N+1 -> instr_valid=1 after N+1.
//     After a redirect, the target word is valid one edge later.
//   Throughput: one instruction per cycle while instr_ready=1.
//   The FSM encoding has three states. An unreachable encoding returns to IDLE.
// TESTING
//   T1 Start, ready=1, memory 0:20010003, 1:20020009, 2:00221020 -> instr/instr_pc sequence
//      20010003/0, 20020009/1, 00221020/2 on consecutive cycles; issue_cnt=3 after 3 loads.
//   T2 Hold ready=0 for 3 cycles while instr=20020009 -> instr, instr_pc=1, pc=2 and issue_cnt
//      are stable. Release -> 00221020 appears the next cycle; no word is dropped or duplicated.
//   T3 Redirect to 0x05 while stalled with instr_pc=3 -> instr_valid=0 the next cycle, then
//      instr_pc=5, instr=20200002. Word 3 is never transferred.
//   T4 HALT_WORD at address 6 -> words 0..5 are issued, then halted=1 and pc=6. HALT_WORD is never
//      valid. Redirect to 0 -> halted=0 and 20010003 is re-fetched.
//   T5 redirect_pc=0xFF, memory[0xFF]=20000000 -> instr_pc=FF, then instr_pc=00 (wrap).
//   T6 Assert rst mid-stall with instr_valid=1 -> all outputs take reset values on that edge,
//      the FSM is in IDLE, and the next start fetches from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads a single-cycle instruction memory and presents each
// fetched word to the decoder through a registered valid/ready output stage.
module instr_fetch_ctrl #(
  parameter int                 ADDR_W    = 8,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFC000000,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rd,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic [CNT_W-1:0]  issue_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              load, flush, halt_set, halt_clr;
  logic              slot_free, is_halt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign imem_addr = pc;
  assign slot_free = !instr_valid || instr_ready;
  assign is_halt   = (imem_rd == HALT_WORD);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    flush     = 1'b0;
    halt_set  = 1'b0;
    halt_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (redirect) pc_nxt = redirect_pc;
        if (start)    state_nxt = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
          flush  = 1'b1;
        end else if (slot_free) begin
          if (is_halt) begin
            // Halt word is consumed by the sequencer itself; pc stays on it.
            state_nxt = S_HALT;
            halt_set  = 1'b1;
            flush     = 1'b1;
          end else begin
            load   = 1'b1;
            pc_nxt = pc + ADDR_W'(1);
          end
        end
      end
      S_HALT: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          halt_clr  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output stage: registered word, its address and the handshake valid
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      issue_cnt   <= '0;
    end else begin
      pc <= pc_nxt;
      if (load) begin
        instr       <= imem_rd;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        issue_cnt   <= sat_inc(issue_cnt);
      end else if (flush) begin
        instr_valid <= 1'b0;
      end
      if (halt_set)      halted <= 1'b1;
      else if (halt_clr) halted <= 1'b0;
    end
  end

endmodule
